// File: rtl/bfs_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : bfs_mem_pkg
// Brief  : Shared types and constants for the BFS memory-fetch path.
// Rev    : 1.0  initial release
// ============================================================================
package bfs_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } sched_state_t;

    localparam int AXI_4K_BOUNDARY = 4096;

    function automatic int calc_bpb(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int   k;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDX_W'(k);
            end
        end
        any_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module : fetch_scheduler
// Brief  : Round-robin share of one AXI read fetcher among BFS requesters,
//          splitting requests into 4 KB-safe bursts and steering beats back.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_scheduler
    import bfs_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*32-1:0]    req_addr,
    input  logic [NUM_REQ*CNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_REQ-1:0]       rd_valid,
    output logic                     busy,
    output logic [31:0]              fetch_addr,
    output logic [7:0]               fetch_num,
    output logic                     fetch_start,
    input  logic                     fetch_done,
    input  logic [DATA_WIDTH-1:0]    fetch_data,
    input  logic                     fetch_data_valid
);

    localparam int BPB      = calc_bpb(DATA_WIDTH);
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int IDX_W    = $clog2(NUM_REQ);

    sched_state_t       state_q, state_d;
    logic [NUM_REQ-1:0] owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               owner_vld_q, owner_vld_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]        cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [8:0]         beats_q, beats_d;
    logic [7:0]         num_q, num_d;
    logic               done_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [31:0]        sel_addr;
    logic [CNT_W-1:0]   sel_cnt;
    logic [12:0]        to_bound;
    logic [12:0]        bound_beats;
    logic [8:0]         rem_clip;
    logic [8:0]         bnd_clip;
    logic [8:0]         issue_beats;
    logic               burst_cmpl;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_cnt  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_oh_q[r]) begin
                sel_addr = req_addr[32*r +: 32];
                sel_cnt  = req_count[CNT_W*r +: CNT_W];
            end
        end
    end

    // Burst length: smallest of remaining beats, MAX_BURST and beats left in this 4 KB page.
    assign to_bound    = 13'(AXI_4K_BOUNDARY) - {1'b0, cur_addr_q[11:0]};
    assign bound_beats = to_bound >> BPB_LOG2;
    assign rem_clip    = (32'(remaining_q) > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining_q);
    assign bnd_clip    = (32'(bound_beats) > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(bound_beats);
    assign issue_beats = (rem_clip < bnd_clip) ? rem_clip : bnd_clip;

    // fetch_done is sticky, so only its rising edge marks completion; never seen in ISSUE.
    assign burst_cmpl = (state_q == ST_WAIT) && fetch_done && !done_q;

    always_comb begin
        state_d     = state_q;
        owner_oh_d  = owner_oh_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        rr_ptr_d    = rr_ptr_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        num_d       = num_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    owner_oh_d  = arb_grant;
                    owner_d     = arb_idx;
                    owner_vld_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                cur_addr_d  = sel_addr;
                remaining_d = sel_cnt;
                rr_ptr_d    = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);
                state_d     = (sel_cnt == '0) ? ST_FIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                beats_d = issue_beats;
                num_d   = 8'(issue_beats - 9'd1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (burst_cmpl) begin
                    cur_addr_d  = cur_addr_q + (32'(beats_q) << BPB_LOG2);
                    remaining_d = remaining_q - CNT_W'(beats_q);
                    state_d     = (remaining_q == CNT_W'(beats_q)) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_FIN: begin
                owner_oh_d  = '0;
                owner_vld_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_oh_q  <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            rr_ptr_q    <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            num_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_oh_q  <= owner_oh_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            num_q       <= num_d;
            done_q      <= fetch_done;
        end
    end

    assign req_ready   = (state_q == ST_GRANT) ? owner_oh_q : '0;
    assign req_done    = (state_q == ST_FIN) ? owner_oh_q : '0;
    assign rd_valid    = fetch_data_valid ? owner_oh_q : '0;
    assign rd_data     = fetch_data;
    assign busy        = owner_vld_q;
    assign fetch_start = (state_q == ST_ISSUE);
    assign fetch_addr  = cur_addr_q;
    assign fetch_num   = (state_q == ST_ISSUE) ? 8'(issue_beats - 9'd1) : num_q;

endmodule
`default_nettype wire
